iir_coef_loader: RTL and testbench
==================================

# iir_coef_loader

Tap-update sequencer that writes new a1/b0/b1 coefficients into a first-order IIR filter with anti-windup without glitching its integrator. A host-side register interface fills staging registers; a commit request freezes the filter via its hold input, swaps all three taps in a single cycle, keeps the hold asserted while the filter pipeline settles, then releases it. The block sits between the host register bank and the filter's tap and hold inputs.

## Interface
- HOLD_PRE, 2, cycles hold_out is asserted before the tap swap (≥1; covers filter pipeline latency)
- HOLD_POST, 2, cycles hold_out stays asserted after the swap cycle (≥1)
- clk_in  input  1  system clock, all logic on rising edge
- rst_in  input  1  asynchronous, active-high reset
- wr_en_in  input  1  staging write strobe
- wr_addr_in  input  2  0=a1, 1=b0, 2=b1, 3=reserved (ignored)
- wr_data_in  input  35 signed  coefficient value
- commit_in  input  1  request to transfer staging to active taps
- a1_out, b0_out, b1_out  output  35 signed each  active taps to filter (registered)
- hold_out  output  1  to filter hold input (registered)
- busy_out  output  1  commit sequence in progress
- pending_out  output  1  staging written since last swap
- done_out  output  1  one-cycle pulse on sequence completion
- wr_drop_out  output  1  one-cycle pulse: write arrived while busy, discarded

## Operation
- States: IDLE, PRE_HOLD, SWAP, POST_HOLD. One down-counter, width ≥ clog2(max(HOLD_PRE,HOLD_POST)+1).
- IDLE: writes with addr 0..2 update the staging register and set pending_out; addr 3 has no effect. commit_in → PRE_HOLD, counter loaded with HOLD_PRE.
- PRE_HOLD: decrement; at terminal count → SWAP.
- SWAP: active taps ← staging (all three same edge); pending_out cleared → POST_HOLD, counter loaded with HOLD_POST.
- POST_HOLD: decrement; at terminal count → IDLE, done_out pulses.
- hold_out = busy_out = 1 in PRE_HOLD, SWAP, POST_HOLD; 0 in IDLE.
- Simultaneous wr_en_in and commit_in in IDLE: the write lands in staging first and is included in the swap.
- Write while busy: staging unchanged, wr_drop_out pulses next cycle. commit_in while busy: ignored (not queued).
- Commit with pending_out = 0 runs the full sequence (re-loads identical taps); no shortcut.
- Values pass through untouched; no saturation, no arithmetic on data.

## Timing
- Reset (asynchronous, immediate): state IDLE; staging and active taps = 0; hold_out, busy_out, pending_out, done_out, wr_drop_out = 0. Asserting reset mid-sequence aborts it; the taps go to 0, not to staging.
- All outputs are registered; no combinational input-to-output paths.
- commit_in sampled high at edge k (IDLE): hold_out/busy_out high from cycle k+1 through k+HOLD_PRE+HOLD_POST+1. SWAP is cycle k+HOLD_PRE+1. New taps are visible from cycle k+HOLD_PRE+2. done_out is high in cycle k+HOLD_PRE+HOLD_POST+2 together with hold_out = 0.
- Defaults: hold high for 5 cycles (k+1..k+5), taps change at k+4, done at k+6.
- A write at edge j updates pending_out in cycle j+1. A commit may be accepted in the same cycle that done_out is high, so back-to-back sequences have one idle cycle.
- Staging writes take no effect on active taps until SWAP.

## Test plan
- Reset check: assert rst_in mid-cycle, asynchronously → all outputs 0 before the next edge; state IDLE.
- Basic load: write a1=0x0_0400_0000, b0=0x7_FFFF_FFFF, b1=−1, then commit at edge k → hold_out high k+1..k+5, taps equal the written values from k+4 and not before, done_out only at k+6, pending_out falls at k+4.
- Same-cycle write and commit: write b0=123 together with commit → b0_out=123 after the swap.
- Busy collisions: write b1=5 and raise commit during PRE_HOLD → wr_drop_out pulses, b1_out is unchanged after the swap, only one done_out occurs, no second sequence.
- Reset mid-sequence: rst_in during POST_HOLD after a swap to nonzero taps → taps 0, hold_out 0, no done_out.
- Parameter sweep HOLD_PRE=1, HOLD_POST=5: commit at k → swap cycle k+2, hold_out high k+1..k+7, done_out at k+8; back-to-back commit on the done cycle is accepted.

Source files
------------

// File: rtl/iir_coef_loader_if.sv
// Host-side staging/commit bus and filter-side tap/hold outputs of the IIR coefficient loader.
// master = host (drives writes and commits), slave = loader.
interface iir_coef_loader_if;
  logic               wr_en_in;
  logic [1:0]         wr_addr_in;
  logic signed [34:0] wr_data_in;
  logic               commit_in;

  logic signed [34:0] a1_out;
  logic signed [34:0] b0_out;
  logic signed [34:0] b1_out;
  logic               hold_out;
  logic               busy_out;
  logic               pending_out;
  logic               done_out;
  logic               wr_drop_out;

  modport master (
    output wr_en_in, wr_addr_in, wr_data_in, commit_in,
    input  a1_out, b0_out, b1_out, hold_out, busy_out, pending_out, done_out, wr_drop_out
  );

  modport slave (
    input  wr_en_in, wr_addr_in, wr_data_in, commit_in,
    output a1_out, b0_out, b1_out, hold_out, busy_out, pending_out, done_out, wr_drop_out
  );
endinterface

// File: rtl/iir_coef_loader.sv
// Glitch-free tap swap for a first-order IIR: stage a1/b0/b1, then freeze the filter,
// swap all three taps on one edge, let the pipeline settle and release the hold.
module iir_coef_loader #(
  parameter int HOLD_PRE  = 2,
  parameter int HOLD_POST = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  iir_coef_loader_if.slave  bus
);
  localparam int CNT_MAX = (HOLD_PRE > HOLD_POST) ? HOLD_PRE : HOLD_POST;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, PRE_HOLD, SWAP, POST_HOLD} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             hold_reg;
  logic             busy_reg;
  logic             pending_reg;
  logic             done_reg;
  logic             wr_drop_reg;
  logic             wr_valid;

  // Address 3 is reserved: it neither lands in staging nor marks staging dirty.
  assign wr_valid = bus.wr_en_in && (bus.wr_addr_in != 2'd3);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      hold_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      pending_reg <= 1'b0;
      done_reg    <= 1'b0;
      wr_drop_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      wr_drop_reg <= bus.wr_en_in && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (wr_valid) begin
            pending_reg <= 1'b1;
          end
          if (bus.commit_in) begin
            state_reg <= PRE_HOLD;
            cnt_reg   <= CNT_W'(HOLD_PRE);
            hold_reg  <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        PRE_HOLD: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= SWAP;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        SWAP: begin
          pending_reg <= 1'b0;
          state_reg   <= POST_HOLD;
          cnt_reg     <= CNT_W'(HOLD_POST);
        end
        POST_HOLD: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= IDLE;
            hold_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // One staging/active register pair per tap: 0=a1, 1=b0, 2=b1.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tap
      logic signed [34:0] staging_reg;
      logic signed [34:0] active_reg;

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          staging_reg <= '0;
          active_reg  <= '0;
        end else begin
          if ((state_reg == IDLE) && bus.wr_en_in && (bus.wr_addr_in == 2'(gi))) begin
            staging_reg <= bus.wr_data_in;
          end
          if (state_reg == SWAP) begin
            active_reg <= staging_reg;
          end
        end
      end
    end
  endgenerate

  assign bus.a1_out      = g_tap[0].active_reg;
  assign bus.b0_out      = g_tap[1].active_reg;
  assign bus.b1_out      = g_tap[2].active_reg;
  assign bus.hold_out    = hold_reg;
  assign bus.busy_out    = busy_reg;
  assign bus.pending_out = pending_reg;
  assign bus.done_out    = done_reg;
  assign bus.wr_drop_out = wr_drop_reg;
endmodule

// File: tb/tb_iir_coef_loader.sv
// Scoreboard bench for iir_coef_loader: default timing (2/2) on dut0 and a 1/5 sweep on dut1.
module tb_iir_coef_loader;
  typedef logic signed [34:0] tap_t;
  typedef struct {
    int   done_edge;
    tap_t tap[3];
  } exp_t;

  localparam int HP[2]  = '{2, 1};
  localparam int HPO[2] = '{2, 5};

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  iir_coef_loader_if bus0();
  iir_coef_loader_if bus1();

  iir_coef_loader #(.HOLD_PRE(2), .HOLD_POST(2)) dut0 (.clk_in(clk_in), .rst_in(rst_in), .bus(bus0));
  iir_coef_loader #(.HOLD_PRE(1), .HOLD_POST(5)) dut1 (.clk_in(clk_in), .rst_in(rst_in), .bus(bus1));

  tap_t tap_o[2][3];
  logic hold_o[2], busy_o[2], pend_o[2], done_o[2], drop_o[2];
  assign tap_o[0][0] = bus0.a1_out;  assign tap_o[1][0] = bus1.a1_out;
  assign tap_o[0][1] = bus0.b0_out;  assign tap_o[1][1] = bus1.b0_out;
  assign tap_o[0][2] = bus0.b1_out;  assign tap_o[1][2] = bus1.b1_out;
  assign hold_o[0] = bus0.hold_out;    assign hold_o[1] = bus1.hold_out;
  assign busy_o[0] = bus0.busy_out;    assign busy_o[1] = bus1.busy_out;
  assign pend_o[0] = bus0.pending_out; assign pend_o[1] = bus1.pending_out;
  assign done_o[0] = bus0.done_out;    assign done_o[1] = bus1.done_out;
  assign drop_o[0] = bus0.wr_drop_out; assign drop_o[1] = bus1.wr_drop_out;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t mon_e;

  // Bench-side view of what each loader should hold.
  tap_t stg[2][3];
  tap_t act[2][3];
  logic pend[2];
  tap_t cur_old[3];
  tap_t cur_new[3];
  logic cur_pend;
  int   cur_k;

  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // Completion monitor: every done_out pulse must match the oldest outstanding commit.
  always @(negedge clk_in) begin
    for (int w = 0; w < 2; w++) begin
      if (done_o[w] === 1'b1) begin
        if ((w == 0 && sb0.size() == 0) || (w == 1 && sb1.size() == 0)) begin
          check($sformatf("dut%0d_spurious_done", w), 64'd1, 64'd0);
        end else begin
          if (w == 0) mon_e = sb0.pop_front();
          else        mon_e = sb1.pop_front();
          check($sformatf("dut%0d_done_edge", w), 64'(edge_cnt), 64'(mon_e.done_edge));
          check($sformatf("dut%0d_done_hold", w), 64'(hold_o[w]), 64'd0);
          for (int t = 0; t < 3; t++)
            check($sformatf("dut%0d_done_tap%0d", w, t), 64'(tap_o[w][t]), 64'(mon_e.tap[t]));
          $display("dut%0d done at edge %0d taps %0h %0h %0h", w, edge_cnt,
                   tap_o[w][0], tap_o[w][1], tap_o[w][2]);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic drive(input int w, input logic en, input logic [1:0] addr, input tap_t data,
                       input logic cm);
    if (w == 0) begin
      bus0.wr_en_in = en; bus0.wr_addr_in = addr; bus0.wr_data_in = data; bus0.commit_in = cm;
    end else begin
      bus1.wr_en_in = en; bus1.wr_addr_in = addr; bus1.wr_data_in = data; bus1.commit_in = cm;
    end
  endtask

  task automatic wr(input int w, input logic [1:0] addr, input tap_t data);
    drive(w, 1'b1, addr, data, 1'b0);
    if (addr != 2'd3) begin
      stg[w][int'(addr)] = data;
      pend[w] = 1'b1;
    end
    step();
    drive(w, 1'b0, 2'd0, '0, 1'b0);
    check($sformatf("dut%0d_wr_pending", w), 64'(pend_o[w]), 64'(pend[w]));
    check($sformatf("dut%0d_wr_nodrop", w), 64'(drop_o[w]), 64'd0);
    $display("dut%0d write addr %0d data %0h pending %0b", w, addr, data, pend_o[w]);
  endtask

  // Drive a commit (optionally with a same-cycle write) and queue its expected completion.
  task automatic start_commit(input int w, input logic en, input logic [1:0] addr, input tap_t data);
    exp_t e;
    drive(w, en, addr, data, 1'b1);
    if (en && addr != 2'd3) begin
      stg[w][int'(addr)] = data;
      pend[w] = 1'b1;
    end
    cur_k    = edge_cnt + 1;
    cur_pend = pend[w];
    for (int t = 0; t < 3; t++) begin
      cur_old[t] = act[w][t];
      cur_new[t] = stg[w][t];
      e.tap[t]   = stg[w][t];
    end
    e.done_edge = cur_k + HP[w] + HPO[w] + 1;
    if (w == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    $display("dut%0d commit at edge %0d expect done at edge %0d", w, cur_k, e.done_edge);
  endtask

  // Cycle-by-cycle window after a commit; n=0 is the first cycle after commit edge k.
  task automatic watch(input int w, input int drop_at, input int last_n);
    int    hp  = HP[w];
    int    hpo = HPO[w];
    string p;
    for (int n = 0; n <= last_n; n++) begin
      step();
      if (n == 0 || (drop_at >= 0 && n == drop_at + 1)) drive(w, 1'b0, 2'd0, '0, 1'b0);
      p = $sformatf("dut%0d_n%0d", w, n);
      check({p, "_hold"}, 64'(hold_o[w]), 64'(n <= hp + hpo));
      check({p, "_busy"}, 64'(busy_o[w]), 64'(n <= hp + hpo));
      check({p, "_pending"}, 64'(pend_o[w]), 64'((n >= hp + 1) ? 1'b0 : cur_pend));
      check({p, "_drop"}, 64'(drop_o[w]), 64'(drop_at >= 0 && n == drop_at + 1));
      for (int t = 0; t < 3; t++)
        check($sformatf("%s_tap%0d", p, t), 64'(tap_o[w][t]),
              64'((n >= hp + 1) ? cur_new[t] : cur_old[t]));
      if (n == drop_at) drive(w, 1'b1, 2'd2, 35'sd5, 1'b1);
    end
    if (last_n >= hp + 1) begin
      for (int t = 0; t < 3; t++) act[w][t] = cur_new[t];
      pend[w] = 1'b0;
    end
  endtask

  task automatic check_zero(input int w, input string tag);
    for (int t = 0; t < 3; t++)
      check($sformatf("dut%0d_%s_tap%0d", w, tag, t), 64'(tap_o[w][t]), 64'd0);
    check($sformatf("dut%0d_%s_hold", w, tag), 64'(hold_o[w]), 64'd0);
    check($sformatf("dut%0d_%s_busy", w, tag), 64'(busy_o[w]), 64'd0);
    check($sformatf("dut%0d_%s_pending", w, tag), 64'(pend_o[w]), 64'd0);
    check($sformatf("dut%0d_%s_done", w, tag), 64'(done_o[w]), 64'd0);
    check($sformatf("dut%0d_%s_drop", w, tag), 64'(drop_o[w]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 2'd0, '0, 1'b0);
    drive(1, 1'b0, 2'd0, '0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      pend[w] = 1'b0;
      for (int t = 0; t < 3; t++) begin stg[w][t] = '0; act[w][t] = '0; end
    end

    step();
    step();
    check_zero(0, "por");
    check_zero(1, "por");
    rst_in = 1'b0;
    step();

    // Basic load with the extreme values; taps must appear exactly at the swap.
    wr(0, 2'd0, 35'h0_0400_0000);
    wr(0, 2'd1, 35'h7_FFFF_FFFF);
    wr(0, 2'd2, -35'sd1);
    start_commit(0, 1'b0, 2'd0, '0);
    watch(0, -1, 5);
    step();

    // Write and commit in the same cycle: the write is part of the swap.
    start_commit(0, 1'b1, 2'd1, 35'sd123);
    watch(0, -1, 5);

    // Write plus commit while busy: dropped, no second sequence.
    wr(0, 2'd0, 35'sd77);
    start_commit(0, 1'b0, 2'd0, '0);
    watch(0, 0, 6);
    check("dut0_post_collision_busy", 64'(busy_o[0]), 64'd0);

    // Reserved address then a commit with nothing pending still runs in full.
    wr(0, 2'd3, 35'sd999);
    start_commit(0, 1'b0, 2'd0, '0);
    watch(0, -1, 5);

    // Asynchronous reset in POST_HOLD after swapping to nonzero taps.
    wr(0, 2'd0, 35'sh1234);
    start_commit(0, 1'b0, 2'd0, '0);
    watch(0, -1, 4);
    rst_in = 1'b1;
    #1;
    check_zero(0, "midrst");
    sb0.delete();
    for (int w = 0; w < 2; w++) begin
      pend[w] = 1'b0;
      for (int t = 0; t < 3; t++) begin stg[w][t] = '0; act[w][t] = '0; end
    end
    step();
    step();
    rst_in = 1'b0;
    step();
    check_zero(0, "after_rst");
    start_commit(0, 1'b0, 2'd0, '0);
    watch(0, -1, 5);

    // Sweep: HOLD_PRE=1, HOLD_POST=5, with a commit accepted on the done cycle.
    wr(1, 2'd0, 35'sd7);
    wr(1, 2'd1, -35'sd300);
    wr(1, 2'd2, 35'h2_AAAA_5555);
    start_commit(1, 1'b0, 2'd0, '0);
    watch(1, -1, 7);
    start_commit(1, 1'b1, 2'd0, 35'sd9);
    watch(1, -1, 7);
    step();
    step();

    check("dut0_sb_empty", 64'(sb0.size()), 64'd0);
    check("dut1_sb_empty", 64'(sb1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
